// File: rtl/acc_drain_requant.sv
// Accumulator drain / requantiser behind the systolic MAC array.
// A tile-done pulse snapshots the whole accumulator matrix. Each row is
// requantised (rounding arithmetic right shift, then saturation to OW bits)
// and streamed out one row per valid/ready beat, so the array can start
// the next tile straight away.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no tile held; tile_done captures acc_in and shift
// CAPT  | buffer loaded; row 0 is requantised into the output register
// DRAIN | beats offered; the next row is loaded on each handshake, and
//       | the handshake on the last row returns to IDLE
module acc_drain_requant #(
    parameter int R  = 16,
    parameter int C  = 12,
    parameter int AW = 48,
    parameter int OW = 16,
    parameter int SW = 6,
    localparam int RW = (R > 1) ? $clog2(R) : 1,
    localparam int CW = $clog2(R * C + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                tile_done,
    input  logic [R*C*AW-1:0]   acc_in,
    input  logic [SW-1:0]       shift,
    output logic [C*OW-1:0]     out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RW-1:0]       out_row,
    output logic                out_last,
    output logic                busy,
    output logic                drain_done,
    output logic [CW-1:0]       sat_cnt,
    output logic                overrun
);

    typedef enum logic [1:0] {IDLE, CAPT, DRAIN} state_t;

    localparam logic [SW-1:0]        SMAX = SW'(AW - 1);
    localparam logic signed [AW:0]   YMAX = {{(AW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [AW:0]   YMIN = {{(AW + 2 - OW){1'b1}}, {(OW - 1){1'b0}}};

    state_t                         state_q, state_d;
    logic [R-1:0][C-1:0][AW-1:0]    buf_q;
    logic [SW-1:0]                  shift_q, shift_d;
    logic [C*OW-1:0]                out_data_q, out_data_d;
    logic                           out_valid_q, out_valid_d;
    logic [RW-1:0]                  out_row_q, out_row_d;
    logic                           out_last_q, out_last_d;
    logic                           busy_q, busy_d;
    logic                           drain_done_q, drain_done_d;
    logic [CW-1:0]                  sat_cnt_q, sat_cnt_d;
    logic                           overrun_q, overrun_d;

    logic [RW-1:0]                  load_row;
    logic [C-1:0][OW-1:0]           row_req;
    logic [C-1:0]                   row_sat;
    logic [CW-1:0]                  row_nsat;
    logic                           hs;

    // Returns {saturated, y}. The AW+1-bit intermediate keeps x + 2^(s-1)
    // from overflowing even for the most positive accumulator value.
    function automatic logic [OW:0] requant(input logic [AW-1:0] x, input logic [SW-1:0] s);
        logic signed [AW:0] t;
        logic signed [AW:0] rnd;
        logic signed [AW:0] y;
        t   = signed'({x[AW-1], x});
        rnd = '0;
        if (s != '0) rnd[s - SW'(1)] = 1'b1;
        y = (t + rnd) >>> s;
        if (y > YMAX)      requant = {1'b1, YMAX[OW-1:0]};
        else if (y < YMIN) requant = {1'b1, YMIN[OW-1:0]};
        else               requant = {1'b0, y[OW-1:0]};
    endfunction

    assign hs       = out_valid_q & out_ready;
    assign load_row = (state_q == CAPT) ? '0 : RW'(out_row_q + 1'b1);

    // Requantise the row that will be loaded next and count its clamped elements.
    always_comb begin
        row_req  = '0;
        row_sat  = '0;
        row_nsat = '0;
        for (int c = 0; c < C; c++) begin
            {row_sat[c], row_req[c]} = requant(buf_q[load_row][c], shift_q);
            row_nsat = row_nsat + CW'(row_sat[c]);
        end
    end

    // Next-state and registered-output logic for the capture/drain sequence.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_row_d    = out_row_q;
        out_last_d   = out_last_q;
        busy_d       = busy_q;
        drain_done_d = 1'b0;
        sat_cnt_d    = sat_cnt_q;
        overrun_d    = overrun_q;
        case (state_q)
            IDLE: begin
                if (tile_done) begin
                    state_d   = CAPT;
                    shift_d   = (32'(shift) >= 32'(AW)) ? SMAX : shift;
                    sat_cnt_d = '0;
                    busy_d    = 1'b1;
                end
            end
            CAPT: begin
                state_d     = DRAIN;
                out_data_d  = row_req;
                out_valid_d = 1'b1;
                out_row_d   = '0;
                out_last_d  = (R == 1);
                sat_cnt_d   = sat_cnt_q + row_nsat;
            end
            DRAIN: begin
                if (hs) begin
                    if (out_last_q) begin
                        state_d      = IDLE;
                        out_valid_d  = 1'b0;
                        out_last_d   = 1'b0;
                        busy_d       = 1'b0;
                        drain_done_d = 1'b1;
                    end else begin
                        out_data_d = row_req;
                        out_row_d  = load_row;
                        out_last_d = (32'(load_row) == 32'(R - 1));
                        sat_cnt_d  = sat_cnt_q + row_nsat;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (tile_done && state_q != IDLE) overrun_d = 1'b1;
    end

    // State and output registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_row_q    <= '0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            drain_done_q <= 1'b0;
            sat_cnt_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_row_q    <= out_row_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            drain_done_q <= drain_done_d;
            sat_cnt_q    <= sat_cnt_d;
            overrun_q    <= overrun_d;
        end
    end

    // Capture buffer: data-only storage, loaded only when a tile is accepted.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && tile_done) buf_q <= acc_in;
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_row    = out_row_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign drain_done = drain_done_q;
    assign sat_cnt    = sat_cnt_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_acc_drain_requant.sv
// Bench for acc_drain_requant on a 4x4 build with 48-bit accumulators and
// 16-bit outputs: table-driven requant tiles plus backpressure, overrun and
// reset-mid-drain sequences.
module tb_acc_drain_requant;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int AW = 48;
    localparam int OW = 16;
    localparam int SW = 6;
    localparam int RW = 2;
    localparam int CW = 5;

    logic                        clk = 1'b0;
    logic                        rstn;
    logic                        tile_done;
    logic [R-1:0][C-1:0][AW-1:0] acc_m;
    logic [SW-1:0]               shift;
    logic [C*OW-1:0]             out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [RW-1:0]               out_row;
    logic                        out_last;
    logic                        busy;
    logic                        drain_done;
    logic [CW-1:0]               sat_cnt;
    logic                        overrun;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    acc_drain_requant #(.R(R), .C(C), .AW(AW), .OW(OW), .SW(SW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .tile_done  (tile_done),
        .acc_in     (acc_m),
        .shift      (shift),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_last   (out_last),
        .busy       (busy),
        .drain_done (drain_done),
        .sat_cnt    (sat_cnt),
        .overrun    (overrun)
    );

    typedef struct packed {
        logic [SW-1:0]         sh;
        logic [C-1:0][AW-1:0]  x;
        logic [C-1:0][OW-1:0]  y;
        logic [7:0]            nsat;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Small-valued tiles used by the sequence tests: kind 0 = A, 1 = B, 2 = C.
    function automatic int tval(input int kind, input int r, input int c);
        case (kind)
            0:       tval = r * 16 + c + 1;
            1:       tval = -(r * 16 + c + 1) - 1000;
            default: tval = 500 + r * 16 + c;
        endcase
    endfunction

    function automatic logic [C*OW-1:0] trow(input int kind, input int r);
        logic [C-1:0][OW-1:0] v;
        for (int c = 0; c < C; c++) v[c] = OW'(tval(kind, r, c));
        trow = v;
    endfunction

    task automatic load_tile(input int kind);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                acc_m[r][c] = AW'(tval(kind, r, c));
    endtask

    // Full tile with out_ready held high; checks latency, every beat and sat_cnt.
    task automatic run_vec(input int i);
        for (int r = 0; r < R; r++) acc_m[r] = vecs[i].x;
        shift     = vecs[i].sh;
        out_ready = 1'b1;
        tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
        chk($sformatf("v%0d_capt_valid", i), out_valid, 0);
        chk($sformatf("v%0d_capt_busy", i), busy, 1);
        for (int r = 0; r < R; r++) begin
            @(negedge clk);
            chk($sformatf("v%0d_r%0d_valid", i, r), out_valid, 1);
            chk($sformatf("v%0d_r%0d_row", i, r), out_row, r);
            chk($sformatf("v%0d_r%0d_last", i, r), out_last, (r == R - 1));
            chk($sformatf("v%0d_r%0d_data", i, r), out_data, vecs[i].y);
        end
        @(negedge clk);
        chk($sformatf("v%0d_dd", i), drain_done, 1);
        chk($sformatf("v%0d_end_valid", i), out_valid, 0);
        chk($sformatf("v%0d_end_busy", i), busy, 0);
        chk($sformatf("v%0d_sat", i), sat_cnt, R * vecs[i].nsat);
        @(negedge clk);
        chk($sformatf("v%0d_dd_off", i), drain_done, 0);
        chk($sformatf("v%0d_sat_hold", i), sat_cnt, R * vecs[i].nsat);
    endtask

    initial begin
        logic stalled, prev_last_hs, rdy;
        logic [C*OW-1:0] held_data;
        logic [RW-1:0] held_row;
        int exp_row, dd_count, post;

        // shift 0 pass-through
        vecs[0].sh = 0;
        vecs[0].x[0] = 48'sd1;  vecs[0].x[1] = -48'sd2; vecs[0].x[2] = 48'sd3;  vecs[0].x[3] = -48'sd4;
        vecs[0].y[0] = 16'sd1;  vecs[0].y[1] = -16'sd2; vecs[0].y[2] = 16'sd3;  vecs[0].y[3] = -16'sd4;
        vecs[0].nsat = 0;
        // shift 1 rounding half toward +inf
        vecs[1].sh = 1;
        vecs[1].x[0] = 48'sd5;  vecs[1].x[1] = -48'sd5; vecs[1].x[2] = 48'sd4;  vecs[1].x[3] = -48'sd1;
        vecs[1].y[0] = 16'sd3;  vecs[1].y[1] = -16'sd2; vecs[1].y[2] = 16'sd2;  vecs[1].y[3] = 16'sd0;
        vecs[1].nsat = 0;
        // shift 3
        vecs[2].sh = 3;
        vecs[2].x[0] = 48'sd12; vecs[2].x[1] = -48'sd12; vecs[2].x[2] = 48'sd7; vecs[2].x[3] = -48'sd4;
        vecs[2].y[0] = 16'sd2;  vecs[2].y[1] = -16'sd1;  vecs[2].y[2] = 16'sd1; vecs[2].y[3] = 16'sd0;
        vecs[2].nsat = 0;
        // shift 60 clamps to 47; max positive checks the widened intermediate
        vecs[3].sh = 60;
        vecs[3].x[0] = 48'h7FFF_FFFF_FFFF; vecs[3].x[1] = 48'h8000_0000_0000;
        vecs[3].x[2] = 48'h4000_0000_0000; vecs[3].x[3] = 48'h3FFF_FFFF_FFFF;
        vecs[3].y[0] = 16'sd1;  vecs[3].y[1] = -16'sd1; vecs[3].y[2] = 16'sd1; vecs[3].y[3] = 16'sd0;
        vecs[3].nsat = 0;
        // saturation at shift 0
        vecs[4].sh = 0;
        vecs[4].x[0] = 48'sd100000; vecs[4].x[1] = -48'sd100000; vecs[4].x[2] = 48'sd32767; vecs[4].x[3] = -48'sd32768;
        vecs[4].y[0] = 16'h7FFF;    vecs[4].y[1] = 16'h8000;     vecs[4].y[2] = 16'h7FFF;   vecs[4].y[3] = 16'h8000;
        vecs[4].nsat = 2;
        // shift 4 with saturation after rounding
        vecs[5].sh = 4;
        vecs[5].x[0] = -48'sd8;  vecs[5].x[1] = 48'sd600000; vecs[5].x[2] = -48'sd600000; vecs[5].x[3] = 48'sd24;
        vecs[5].y[0] = 16'sd0;   vecs[5].y[1] = 16'h7FFF;    vecs[5].y[2] = 16'h8000;     vecs[5].y[3] = 16'sd2;
        vecs[5].nsat = 2;
        // shift 48 == AW also clamps to 47
        vecs[6].sh = 48;
        vecs[6].x[0] = 48'h4000_0000_0000; vecs[6].x[1] = -48'sd1;
        vecs[6].x[2] = 48'sd5;             vecs[6].x[3] = 48'hBFFF_FFFF_FFFF;
        vecs[6].y[0] = 16'sd1;  vecs[6].y[1] = 16'sd0;  vecs[6].y[2] = 16'sd0;  vecs[6].y[3] = -16'sd1;
        vecs[6].nsat = 0;

        rstn = 1'b0; tile_done = 1'b0; out_ready = 1'b0; shift = '0; acc_m = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dd", drain_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_last", out_last, 0);
        chk("rst_row", out_row, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sat", sat_cnt, 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Backpressure: random ready, beats held while stalled, rows in order.
        load_tile(0); shift = '0; out_ready = 1'b0;
        tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
        stalled = 1'b0; prev_last_hs = 1'b0; exp_row = 0; dd_count = 0; post = 0;
        held_data = '0; held_row = '0;
        for (int cyc = 0; cyc < 300 && post < 3; cyc++) begin
            @(negedge clk);
            if (drain_done || prev_last_hs) chk("bp_dd_timing", drain_done, prev_last_hs);
            if (drain_done) dd_count++;
            if (stalled) begin
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_data", out_data, held_data);
                chk("bp_hold_row", out_row, held_row);
            end
            if (out_valid) begin
                chk("bp_row", out_row, exp_row);
                chk("bp_data", out_data, trow(0, exp_row));
            end
            rdy = 1'($urandom_range(0, 1));
            out_ready = rdy;
            prev_last_hs = out_valid & rdy & out_last;
            stalled = out_valid & !rdy;
            held_data = out_data;
            held_row = out_row;
            if (out_valid & rdy) exp_row++;
            if (dd_count > 0) post++;
        end
        chk("bp_rows", exp_row, R);
        chk("bp_dd_count", dd_count, 1);

        // Overrun: tile_done during CAPT and on the last handshake are ignored;
        // tile_done in the drain_done cycle is captured.
        out_ready = 1'b1;
        load_tile(0); tile_done = 1'b1;
        @(negedge clk);
        load_tile(1); tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
        chk("ov_set", overrun, 1);
        chk("ov_r0", out_data, trow(0, 0));
        for (int r = 1; r < R; r++) begin
            @(negedge clk);
            chk($sformatf("ov_r%0d", r), out_data, trow(0, r));
        end
        chk("ov_last", out_last, 1);
        load_tile(1); tile_done = 1'b1;
        @(negedge clk);
        chk("ov_dd", drain_done, 1);
        chk("ov_idle_valid", out_valid, 0);
        load_tile(2); tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
        chk("ov_new_busy", busy, 1);
        chk("ov_sticky", overrun, 1);
        for (int r = 0; r < R; r++) begin
            @(negedge clk);
            chk($sformatf("ov_c_r%0d_row", r), out_row, r);
            chk($sformatf("ov_c_r%0d", r), out_data, trow(2, r));
        end
        @(negedge clk);
        chk("ov_c_dd", drain_done, 1);
        chk("ov_sticky2", overrun, 1);

        // Reset mid-drain while row 3 is offered.
        for (int r = 0; r < R; r++) acc_m[r] = vecs[4].x;
        shift = vecs[4].sh; out_ready = 1'b1; tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
        repeat (R) @(negedge clk);
        chk("rm_row3", out_row, 3);
        chk("rm_sat_pre", sat_cnt, 4 * 2);
        rstn = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("rm_valid", out_valid, 0);
        chk("rm_busy", busy, 0);
        chk("rm_overrun", overrun, 0);
        chk("rm_sat", sat_cnt, 0);
        chk("rm_row", out_row, 0);
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rm_quiet_valid", out_valid, 0);
            chk("rm_quiet_dd", drain_done, 0);
        end
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
